stopwatch_core: RTL

Millisecond stopwatch that consumes the divided `ms_clk` toggle from the clock-divider stage and turns each toggle edge into one millisecond of elapsed time. It keeps ms/sec/min counts with start/stop, lap-freeze and clear control, and feeds the seven-segment display path. The block runs entirely in the 100 MHz `clk` domain and treats `ms_clk` as a data input, not as a clock.

---
 rtl/stopwatch_pkg.sv | 10 +
 rtl/toggle_tick_sync.sv | 21 ++
 rtl/stopwatch_core.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, default limits and count widths for the stopwatch
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
    localparam int MS_W = 10;
    localparam int SEC_W = 6;
    localparam int MIN_W = 7;
    localparam int MS_MAX_DEF = 999;
    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 99;
endpackage

// File: rtl/toggle_tick_sync.sv
// toggle_tick_sync: synchronizes a divider toggle and emits a one-cycle tick per transition
module toggle_tick_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic toggle_i,
    output logic tick_o
);
    logic sync1_q, sync2_q, hist_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= toggle_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end
    assign tick_o = sync2_q ^ hist_q;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: ms/sec/min stopwatch with start/stop, lap freeze, clear and saturation
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MS_MAX  = MS_MAX_DEF,
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ms_clk_i,
    input  logic             start_stop_i,
    input  logic             lap_i,
    input  logic             clear_i,
    output logic [MS_W-1:0]  ms_count_o,
    output logic [SEC_W-1:0] sec_count_o,
    output logic [MIN_W-1:0] min_count_o,
    output logic [MS_W-1:0]  disp_ms_o,
    output logic [SEC_W-1:0] disp_sec_o,
    output logic [MIN_W-1:0] disp_min_o,
    output logic             running_o,
    output logic             lap_hold_o,
    output logic             overflow_o
);
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_MAX);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);

    logic tick;
    toggle_tick_sync u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .toggle_i(ms_clk_i),
        .tick_o  (tick)
    );

    // {start_stop, lap, clear}: level history plus registered rising-edge pulse
    logic [2:0] ctl_q, rise_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctl_q  <= '0;
            rise_q <= '0;
        end else begin
            ctl_q  <= {start_stop_i, lap_i, clear_i};
            rise_q <= {start_stop_i, lap_i, clear_i} & ~ctl_q;
        end
    end

    state_e state_q, state_d;
    logic [MS_W-1:0]  ms_q, ms_d, lap_ms_q, lap_ms_d;
    logic [SEC_W-1:0] sec_q, sec_d, lap_sec_q, lap_sec_d;
    logic [MIN_W-1:0] min_q, min_d, lap_min_q, lap_min_d;
    logic hold_q, hold_d, ovf_q, ovf_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            ms_q      <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            lap_ms_q  <= '0;
            lap_sec_q <= '0;
            lap_min_q <= '0;
            hold_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            lap_ms_q  <= lap_ms_d;
            lap_sec_q <= lap_sec_d;
            lap_min_q <= lap_min_d;
            hold_q    <= hold_d;
            ovf_q     <= ovf_d;
        end
    end

    logic at_max;
    assign at_max = (ms_q == MS_LAST) && (sec_q == SEC_LAST) && (min_q == MIN_LAST);

    always_comb begin
        state_d   = state_q;
        ms_d      = ms_q;
        sec_d     = sec_q;
        min_d     = min_q;
        lap_ms_d  = lap_ms_q;
        lap_sec_d = lap_sec_q;
        lap_min_d = lap_min_q;
        hold_d    = hold_q;
        ovf_d     = ovf_q;
        if (rise_q[0]) begin
            state_d   = IDLE;
            ms_d      = '0;
            sec_d     = '0;
            min_d     = '0;
            lap_ms_d  = '0;
            lap_sec_d = '0;
            lap_min_d = '0;
            hold_d    = 1'b0;
            ovf_d     = 1'b0;
        end else begin
            if (rise_q[2])
                state_d = (state_q == RUN) ? PAUSE :
                          (state_q == PAUSE && ovf_q) ? PAUSE : RUN;
            if (rise_q[1]) begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else if (state_q == RUN) begin
                    hold_d    = 1'b1;
                    lap_ms_d  = ms_q;
                    lap_sec_d = sec_q;
                    lap_min_d = min_q;
                end
            end
            // tick judged against the pre-edge state, so a stop on the same edge still counts
            if (tick && state_q == RUN) begin
                if (at_max) begin
                    ovf_d   = 1'b1;
                    state_d = PAUSE;
                end else if (ms_q != MS_LAST) begin
                    ms_d = ms_q + MS_W'(1);
                end else begin
                    ms_d  = '0;
                    sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + SEC_W'(1);
                    min_d = (sec_q == SEC_LAST) ? min_q + MIN_W'(1) : min_q;
                end
            end
        end
    end

    assign ms_count_o  = ms_q;
    assign sec_count_o = sec_q;
    assign min_count_o = min_q;
    assign disp_ms_o   = hold_q ? lap_ms_q : ms_q;
    assign disp_sec_o  = hold_q ? lap_sec_q : sec_q;
    assign disp_min_o  = hold_q ? lap_min_q : min_q;
    assign running_o   = (state_q == RUN);
    assign lap_hold_o  = hold_q;
    assign overflow_o  = ovf_q;
endmodule
